cabac_se_pair_serializer: RTL and testbench

//  Consumes one CU's parallel syntax-element pair bundle (up to 10 x 21-bit se_pair words from the intra/inter SE prepare stage)
//  and issues the non-empty pairs one at a time, in slot order, to the CABAC binarizer over a valid/ready handshake.

---
 rtl/cabac_se_pair_serializer_pkg.sv | 29 ++
 rtl/cabac_se_pair_find_next.sv | 27 ++
 rtl/cabac_se_pair_serializer.sv | 143 ++++++++++++++
 tb/tb_cabac_se_pair_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_se_pair_serializer_pkg.sv
// Shared constants and types for the CABAC syntax-element pair serializer.
// Field layout of a se_pair word and the serializer FSM encoding.
package cabac_se_pair_serializer_pkg;

    localparam int SE_NUM_PAIR = 10;
    localparam int SE_CNT_W    = 4;

    localparam int VAL_MSB = 20;
    localparam int VAL_LSB = 13;
    localparam int BIN_MSB = 12;
    localparam int BIN_LSB = 9;
    localparam int CTX_MSB = 8;
    localparam int CTX_LSB = 0;

    localparam int SE_PAIR_W = VAL_MSB + 1;

    typedef struct packed {
        logic [VAL_MSB-VAL_LSB:0] val;
        logic [BIN_MSB-BIN_LSB:0] bin;
        logic [CTX_MSB-CTX_LSB:0] ctx;
    } se_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/cabac_se_pair_find_next.sv
// Lowest-set-bit finder over the pending slot mask.
// Also flags whether the found slot is the only one still pending.
module cabac_se_pair_find_next
    import cabac_se_pair_serializer_pkg::*;
#(
    parameter int NUM_PAIR = SE_NUM_PAIR,
    parameter int CNT_W    = SE_CNT_W
) (
    input  logic [NUM_PAIR-1:0] mask,
    output logic                found,
    output logic [CNT_W-1:0]    index,
    output logic                is_last
);

    // Scan high to low so the lowest pending slot wins; x & (x-1) drops it.
    always_comb begin
        found   = |mask;
        index   = '0;
        for (int i = NUM_PAIR - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = CNT_W'(i);
            end
        end
        is_last = found && ((mask & (mask - NUM_PAIR'(1))) == '0);
    end

endmodule

// File: rtl/cabac_se_pair_serializer.sv
// Serializes one CU's parallel se_pair bundle into a valid/ready stream,
// skipping empty (all-zero) slots and flagging the last emitted pair.
module cabac_se_pair_serializer
    import cabac_se_pair_serializer_pkg::*;
#(
    parameter int NUM_PAIR = SE_NUM_PAIR,
    parameter int CNT_W    = SE_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [NUM_PAIR*SE_PAIR_W-1:0] se_pairs_i,
    output logic                          busy_o,
    output logic [SE_PAIR_W-1:0]          se_pair_o,
    output logic                          se_valid_o,
    input  logic                          se_ready_i,
    output logic                          se_last_o,
    output logic                          done_o,
    output logic [CNT_W-1:0]              pair_cnt_o
);

    ser_state_t          state_q;
    ser_state_t          state_d;
    se_pair_t            bundle_q [NUM_PAIR];
    se_pair_t            in_word  [NUM_PAIR];
    logic [NUM_PAIR-1:0] in_mask;
    logic [NUM_PAIR-1:0] mask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;
    logic                hs;
    logic                found;
    logic [CNT_W-1:0]    idx;
    logic                is_last;

    cabac_se_pair_find_next #(
        .NUM_PAIR (NUM_PAIR),
        .CNT_W    (CNT_W)
    ) u_find_next (
        .mask    (mask_q),
        .found   (found),
        .index   (idx),
        .is_last (is_last)
    );

    // Split the incoming flat bundle into slots and mark non-empty ones.
    always_comb begin
        for (int k = 0; k < NUM_PAIR; k++) begin
            in_word[k] = se_pairs_i[k*SE_PAIR_W +: SE_PAIR_W];
            in_mask[k] = (in_word[k] != '0);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything including start.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        hs      = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        accept  = 1'b1;
                        state_d = (|in_mask) ? ST_SEND : ST_DONE;
                    end
                end
                ST_SEND: begin
                    if (se_ready_i) begin
                        hs = 1'b1;
                        if (is_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Bundle capture on an accepted start only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PAIR; k++) begin
                bundle_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_PAIR; k++) begin
                bundle_q[k] <= in_word[k];
            end
        end
    end

    // Pending mask: load at start, drop lowest pending slot per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (clear_i) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= in_mask;
        end else if (hs) begin
            mask_q <= mask_q & (mask_q - NUM_PAIR'(1));
        end
    end

    // Emitted-pair counter; survives clear, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!clear_i && accept) begin
            cnt_q <= '0;
        end else if (hs && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Outputs decode registered state only, so ready never reaches valid.
    always_comb begin
        se_valid_o = (state_q == ST_SEND) && found;
        busy_o     = (state_q == ST_SEND);
        done_o     = (state_q == ST_DONE);
        se_pair_o  = se_valid_o ? bundle_q[idx] : '0;
        se_last_o  = se_valid_o && is_last;
        pair_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_cabac_se_pair_serializer.sv
// Directed, table-driven bench for the se_pair serializer.
// Vectors plus hand sequences for restart, clear and async reset.
module tb_cabac_se_pair_serializer;

    localparam int NP = 10;
    localparam int PW = 21;
    localparam int BW = NP * PW;

    logic          clk;
    logic          rst_n;
    logic          clear_i;
    logic          start_i;
    logic [BW-1:0] se_pairs_i;
    logic          busy_o;
    logic [PW-1:0] se_pair_o;
    logic          se_valid_o;
    logic          se_ready_i;
    logic          se_last_o;
    logic          done_o;
    logic [3:0]    pair_cnt_o;

    int tests;
    int fails;

    typedef struct {
        logic [BW-1:0] bundle;
        bit            rnd;
        int            exp_n;
        logic [PW-1:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    cabac_se_pair_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .se_pairs_i (se_pairs_i),
        .busy_o     (busy_o),
        .se_pair_o  (se_pair_o),
        .se_valid_o (se_valid_o),
        .se_ready_i (se_ready_i),
        .se_last_o  (se_last_o),
        .done_o     (done_o),
        .pair_cnt_o (pair_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk_full();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NP; k++) begin
            b[k*PW +: PW] = PW'(k + 1);
        end
        return b;
    endfunction

    function automatic logic [BW-1:0] mk_intra();
        logic [BW-1:0] b;
        b = '0;
        b[0*PW +: PW] = 21'h001208;
        b[1*PW +: PW] = 21'h002201;
        b[4*PW +: PW] = 21'h005603;
        b[5*PW +: PW] = 21'h00800F;
        return b;
    endfunction

    function automatic logic [BW-1:0] mk_slot9();
        logic [BW-1:0] b;
        b = '0;
        b[9*PW +: PW] = 21'h1FFFFF;
        return b;
    endfunction

    // Start a bundle and follow it to done_o, checking every output cycle.
    // mode 1 also pulses start with another bundle mid-run and at done_o.
    task automatic run_bundle(input logic [BW-1:0] b, input bit rnd,
                              input int exp_n, input logic [PW-1:0] exp_last,
                              input bit mode);
        logic [PW-1:0] exp_q [$];
        logic [PW-1:0] held;
        bit            stalled;
        bit            seen_done;
        bit            rdy;
        int            got;
        int            c;
        for (int k = 0; k < NP; k++) begin
            if (b[k*PW +: PW] != '0) exp_q.push_back(b[k*PW +: PW]);
        end
        chk("model_count", exp_q.size(), exp_n);
        @(negedge clk);
        se_pairs_i = b;
        start_i    = 1'b1;
        se_ready_i = 1'b0;
        @(negedge clk);
        start_i    = 1'b0;
        got        = 0;
        stalled    = 1'b0;
        seen_done  = 1'b0;
        held       = '0;
        c          = 1;
        while (c < 200 && !seen_done) begin
            if (c == 1) begin
                chk("first_valid", se_valid_o, exp_n > 0);
                chk("first_done", done_o, exp_n == 0);
            end
            if (stalled) begin
                chk("stall_valid", se_valid_o, 1);
                chk("stall_hold", se_pair_o, held);
            end
            if (se_valid_o) begin
                chk("busy_w_valid", busy_o, 1);
                if (got < exp_n) begin
                    chk("pair", se_pair_o, exp_q[got]);
                    chk("last", se_last_o, got == exp_n - 1);
                end else begin
                    chk("extra_pair", got, exp_n - 1);
                end
            end
            if (done_o) begin
                seen_done = 1'b1;
                chk("done_pairs", got, exp_n);
                chk("done_busy", busy_o, 0);
                chk("done_valid", se_valid_o, 0);
                chk("pair_cnt", pair_cnt_o, exp_n);
                if (!rnd) chk("done_cycle", c, exp_n + 1);
                if (mode) begin
                    se_pairs_i = mk_intra();
                    start_i    = 1'b1;
                end
            end else begin
                if (mode && got == 3) begin
                    se_pairs_i = mk_slot9();
                    start_i    = 1'b1;
                end else begin
                    start_i = 1'b0;
                end
            end
            rdy        = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            se_ready_i = rdy;
            stalled    = se_valid_o && !rdy;
            held       = se_pair_o;
            if (se_valid_o && rdy) got++;
            @(negedge clk);
            c++;
        end
        start_i = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("idle_done", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_valid", se_valid_o, 0);
        chk("idle_cnt", pair_cnt_o, exp_n);
        if (mode) begin
            @(negedge clk);
            chk("restart_ign", busy_o | se_valid_o | done_o, 0);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        clear_i    = 1'b0;
        start_i    = 1'b0;
        se_ready_i = 1'b0;
        se_pairs_i = '0;

        vecs[0] = '{mk_full(),  1'b0, 10, 21'h00000A};
        vecs[1] = '{mk_intra(), 1'b0, 4,  21'h00800F};
        vecs[2] = '{'0,         1'b0, 0,  21'h000000};
        vecs[3] = '{mk_full(),  1'b1, 10, 21'h00000A};
        vecs[4] = '{mk_slot9(), 1'b0, 1,  21'h1FFFFF};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", se_valid_o, 0);
        chk("rst_pair", se_pair_o, 0);
        chk("rst_last", se_last_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", pair_cnt_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_bundle(vecs[i].bundle, vecs[i].rnd, vecs[i].exp_n,
                       vecs[i].exp_last, 1'b0);
        end

        // Restart mid-bundle and at done_o must both be ignored.
        run_bundle(mk_full(), 1'b0, 10, 21'h00000A, 1'b1);

        // Clear after three handshakes, with start in the same cycle.
        @(negedge clk);
        se_pairs_i = mk_full();
        start_i    = 1'b1;
        se_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_clr_pair", se_pair_o, 21'h000004);
        clear_i    = 1'b1;
        start_i    = 1'b1;
        se_pairs_i = mk_intra();
        @(negedge clk);
        clear_i = 1'b0;
        start_i = 1'b0;
        chk("clr_valid", se_valid_o, 0);
        chk("clr_busy", busy_o, 0);
        chk("clr_done", done_o, 0);
        chk("clr_cnt", pair_cnt_o, 3);
        repeat (3) begin
            @(negedge clk);
            chk("clr_quiet", busy_o | se_valid_o | done_o, 0);
        end
        run_bundle(mk_intra(), 1'b0, 4, 21'h00800F, 1'b0);

        // Asynchronous reset in the middle of a bundle.
        @(negedge clk);
        se_pairs_i = mk_full();
        start_i    = 1'b1;
        se_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", se_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_valid", se_valid_o, 0);
        chk("arst_pair", se_pair_o, 0);
        chk("arst_last", se_last_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_cnt", pair_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_bundle(mk_full(), 1'b0, 10, 21'h00000A, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
